// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
//
// Two-port arbiter/sequencer in front of the single-ported data_memory block.
// Port 0 is the core load/store unit, port 1 is the loader/debug port. Each
// transaction takes exactly three cycles (IDLE -> ACCESS -> RESP) with no
// overlap. The memory's combinational read data is registered at the end of
// ACCESS and returned to the winning port in RESP.
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  defined   : a tie goes to the port not granted last
//                            undefined : fixed priority, port 0 wins every tie
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   pN_req / pN_we               request and direction (1 = write)
//   pN_addr / pN_wdata           word address and write data
//   pN_gnt                       one-cycle grant pulse (ACCESS cycle)
//   pN_rvalid                    one-cycle completion pulse (RESP cycle)
//   pN_rdata / pN_err            read data / out-of-range flag, valid with rvalid
//   mem_read_enable, mem_write_enable, mem_address, mem_write_data
//                                strobes and operands to data_memory
//   mem_read_data                combinational read data from data_memory
//   busy                         high whenever the FSM is not in IDLE
//   dbg_state                    current FSM state, for observation only
//
// Handshake: a requester raises req with we/addr/wdata stable and holds all of
// them until it sees gnt; requests are only sampled in IDLE. The grant is
// followed one cycle later by exactly one rvalid pulse on the same port,
// unless reset intervenes, in which case the transaction is silently dropped.
// ---------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int NUM_WORDS = 1024,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so the unsigned range check sees every address bit.
    localparam logic [ADDR_W:0] NUM_WORDS_EXT = (ADDR_W + 1)'(NUM_WORDS);

    state_t            state_q, state_d;
    logic              win_q, win_d;        // 0 = port 0 owns the transaction
    logic              we_q, we_d;
    logic              oor_q, oor_d;        // address out of range
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    // Winner selection for the request currently presented in IDLE.
    logic              pick_p1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic prio_p1_q, prio_p1_d;             // 1 = port 1 wins the next tie

    assign pick_p1 = p1_req & (~p0_req | prio_p1_q);

    // The pointer moves on every grant, including uncontested ones.
    always_comb begin
        prio_p1_d = prio_p1_q;
        if (state_q == IDLE && (p0_req || p1_req)) begin
            prio_p1_d = ~pick_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio_p1_q <= 1'b0;
        end else begin
            prio_p1_q <= prio_p1_d;
        end
    end
`else
    assign pick_p1 = p1_req & ~p0_req;
`endif

    assign sel_we       = pick_p1 ? p1_we    : p0_we;
    assign sel_addr     = pick_p1 ? p1_addr  : p0_addr;
    assign sel_wdata    = pick_p1 ? p1_wdata : p0_wdata;
    assign sel_in_range = {1'b0, sel_addr} < NUM_WORDS_EXT;

    // Next-state and next-output logic; every output is registered, so the
    // values computed here appear during the state being entered.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        oor_d       = oor_q;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = '0;
        rdata1_d    = '0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = ACCESS;
                    win_d   = pick_p1;
                    we_d    = sel_we;
                    oor_d   = ~sel_in_range;
                    gnt_d   = pick_p1 ? 2'b10 : 2'b01;
                    if (sel_in_range) begin
                        mem_addr_d  = sel_addr;
                        mem_we_d    = sel_we;
                        mem_re_d    = ~sel_we;
                        mem_wdata_d = sel_we ? sel_wdata : '0;
                    end
                end
            end
            ACCESS: begin
                state_d  = RESP;
                rvalid_d = win_q ? 2'b10 : 2'b01;
                err_d    = oor_q ? rvalid_d : 2'b00;
                if (!we_q && !oor_q) begin
                    if (win_q) begin
                        rdata1_d = mem_read_data;
                    end else begin
                        rdata0_d = mem_read_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    // The memory commits on the edge that ends ACCESS. Qualifying the strobes
    // with reset means a reset landing on that edge cancels the commit.
    assign mem_read_enable  = mem_re_q & ~reset;
    assign mem_write_enable = mem_we_q & ~reset;
    assign mem_address      = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
